// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder slice.
package mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 4;

    // Default byte address of the completion mailbox.
    localparam logic [ADDR_W-1:0] DEFAULT_DONE_ADDR = 32'h0000_0FC4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read, contents not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = 6
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Commit one word per enabled edge.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-mapped responder with programmable wait states.
// Optional completion mailbox enabled by defining MEM_MAILBOX_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned       DEPTH       = 64,
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] DONE_ADDR   = DEFAULT_DONE_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              done,
    output logic [DATA_W-1:0] done_value
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_MAILBOX_EN
    localparam bit MBOX_EN = 1'b1;
`else
    localparam bit MBOX_EN = 1'b0;
`endif

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept_c;
    logic [ADDR_W-1:0] eff_addr_c;
    logic              eff_we_c;
    logic              eff_mbox_c;
    logic              eff_err_c;
    logic              q_mbox_c;
    logic [DATA_W-1:0] ram_rdata_c;
    logic [DATA_W-1:0] rsp_rdata_c;
    logic              ram_wen_c;

    assign accept_c = (state == IDLE) && req;

    // In IDLE the live request is the transaction; afterwards only captured values count.
    assign eff_addr_c = (state == IDLE) ? addr : addr_q;
    assign eff_we_c   = (state == IDLE) ? we   : we_q;

    assign eff_mbox_c = MBOX_EN && (eff_addr_c == DONE_ADDR);
    assign q_mbox_c   = MBOX_EN && (addr_q == DONE_ADDR);

    assign eff_err_c  = (eff_addr_c[1:0] != 2'b00) ||
                        (({2'b00, eff_addr_c[ADDR_W-1:2]} >= 32'(DEPTH)) && !eff_mbox_c);

    assign rsp_rdata_c = (eff_we_c || eff_err_c) ? '0 :
                         eff_mbox_c              ? done_value : ram_rdata_c;

    // err is registered and only set during RESP, so it qualifies the commit.
    assign ram_wen_c = (state == RESP) && we_q && !err && !q_mbox_c;

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem_array (
        .clk     (clk),
        .wen     (ram_wen_c),
        .waddr   (IDX_W'(addr_q[ADDR_W-1:2])),
        .wdata   (wdata_q),
        .raddr   (IDX_W'(eff_addr_c[ADDR_W-1:2])),
        .rdata_c (ram_rdata_c)
    );

    // FSM state and wait counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the request at acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept_c) begin
            addr_q  <= addr;
            we_q    <= we;
            wdata_q <= wdata;
        end
    end

    // Registered response: valid only for the single cycle spent in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else if (state_d == RESP) begin
            ready <= 1'b1;
            err   <= eff_err_c;
            rdata <= rsp_rdata_c;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end
    end

`ifdef MEM_MAILBOX_EN
    logic done_wr_c;
    assign done_wr_c = (state == RESP) && we_q && !err && q_mbox_c;

    // Sticky completion flag and last mailbox value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done       <= 1'b0;
            done_value <= '0;
        end else if (done_wr_c) begin
            done       <= 1'b1;
            done_value <= wdata_q;
        end
    end
`else
    assign done       = 1'b0;
    assign done_value = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench: u0 has WAIT_CYCLES=2, u1 has WAIT_CYCLES=0.
module tb_mem_responder;
    import mem_pkg::*;

    logic             clk;
    logic             reset;
    logic [1:0]       req_v;
    logic [1:0]       we_v;
    logic [1:0][31:0] addr_v;
    logic [1:0][31:0] wdata_v;
    logic [1:0]       ready_v;
    logic [1:0][31:0] rdata_v;
    logic [1:0]       err_v;
    logic [1:0]       done_v;
    logic [1:0][31:0] done_value_v;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        e;
    int          lat;

    mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .reset(reset), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .ready(ready_v[0]), .rdata(rdata_v[0]), .err(err_v[0]),
        .done(done_v[0]), .done_value(done_value_v[0])
    );

    mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .ready(ready_v[1]), .rdata(rdata_v[1]), .err(err_v[1]),
        .done(done_v[1]), .done_value(done_value_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction; latency counts negedges after the accepting edge until ready.
    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic scramble, output logic [31:0] rdo, output logic eo,
                       output int lato);
        @(negedge clk);
        req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = wd;
        @(posedge clk);
        lato = -1; rdo = '0; eo = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_v[d] = 1'b0;
                if (scramble) begin
                    addr_v[d]  = a + 32'h4;
                    wdata_v[d] = 32'h0000_0BAD;
                end
            end
            if (ready_v[d]) begin
                lato = k; rdo = rdata_v[d]; eo = err_v[d];
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        req_v = '0; we_v = '0; addr_v = '0; wdata_v = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ready", 32'(ready_v[0]), 32'd0);
        chk("rst_err", 32'(err_v[0]), 32'd0);
        chk("rst_rdata", rdata_v[0], 32'd0);
        chk("rst_done", 32'(done_v[0]), 32'd0);
        chk("rst_done_value", done_value_v[0], 32'd0);
        reset = 1'b1;

        // Write 7 to 0x64 then read back, 3-cycle latency
        txn(0, 1'b1, 32'h64, 32'h0000_0007, 1'b0, rd, e, lat);
        chk("wr64_lat", 32'(lat), 32'd3);
        chk("wr64_err", 32'(e), 32'd0);
        @(negedge clk);
        chk("ready_pulse_low", 32'(ready_v[0]), 32'd0);
        chk("rdata_idle_zero", rdata_v[0], 32'd0);
        txn(0, 1'b0, 32'h64, 32'h0, 1'b0, rd, e, lat);
        chk("rd64_lat", 32'(lat), 32'd3);
        chk("rd64_data", rd, 32'h0000_0007);
        chk("rd64_err", 32'(e), 32'd0);

        // Zero wait states, misaligned accesses
        txn(1, 1'b1, 32'h04, 32'h0000_0077, 1'b0, rd, e, lat);
        chk("u1_wr04_lat", 32'(lat), 32'd1);
        txn(1, 1'b0, 32'h02, 32'h0, 1'b0, rd, e, lat);
        chk("u1_rd02_lat", 32'(lat), 32'd1);
        chk("u1_rd02_err", 32'(e), 32'd1);
        chk("u1_rd02_data", rd, 32'd0);
        txn(1, 1'b1, 32'h06, 32'h0000_0099, 1'b0, rd, e, lat);
        chk("u1_wr06_err", 32'(e), 32'd1);
        txn(1, 1'b0, 32'h04, 32'h0, 1'b0, rd, e, lat);
        chk("u1_rd04_data", rd, 32'h0000_0077);
        chk("u1_rd04_err", 32'(e), 32'd0);

        // Range boundary: word 63 valid, word 64 errors without corrupting word 0
        txn(0, 1'b1, 32'h00, 32'h5555_AAAA, 1'b0, rd, e, lat);
        txn(0, 1'b1, 32'hFC, 32'h0000_3F3F, 1'b0, rd, e, lat);
        chk("wrFC_err", 32'(e), 32'd0);
        txn(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, rd, e, lat);
        chk("wr100_err", 32'(e), 32'd1);
        txn(0, 1'b0, 32'h00, 32'h0, 1'b0, rd, e, lat);
        chk("rd00_data", rd, 32'h5555_AAAA);
        txn(0, 1'b0, 32'hFC, 32'h0, 1'b0, rd, e, lat);
        chk("rdFC_data", rd, 32'h0000_3F3F);
        txn(0, 1'b0, 32'h100, 32'h0, 1'b0, rd, e, lat);
        chk("rd100_err", 32'(e), 32'd1);
        chk("rd100_data", rd, 32'd0);

        // Inputs changed during WAIT are ignored
        txn(0, 1'b1, 32'h24, 32'h0000_1111, 1'b0, rd, e, lat);
        txn(0, 1'b1, 32'h20, 32'h0000_CAFE, 1'b1, rd, e, lat);
        chk("scr_wr_err", 32'(e), 32'd0);
        txn(0, 1'b0, 32'h20, 32'h0, 1'b1, rd, e, lat);
        chk("scr_rd20", rd, 32'h0000_CAFE);
        txn(0, 1'b0, 32'h24, 32'h0, 1'b0, rd, e, lat);
        chk("scr_rd24", rd, 32'h0000_1111);

        // Reset during WAIT of a write aborts it
        txn(0, 1'b1, 32'h10, 32'hAAAA_0000, 1'b0, rd, e, lat);
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h10; wdata_v[0] = 32'h0000_1234;
        @(posedge clk);
        @(negedge clk);
        req_v[0] = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_state", 32'(u0.state), 32'(IDLE));
        chk("abort_ready", 32'(ready_v[0]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_ready", 32'(ready_v[0]), 32'd0);
        end
        reset = 1'b1;
        txn(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, e, lat);
        chk("abort_rd10", rd, 32'hAAAA_0000);

        // Completion mailbox
        txn(0, 1'b1, 32'hFC4, 32'h0000_0400, 1'b0, rd, e, lat);
`ifdef MEM_MAILBOX_EN
        chk("mbox_wr_err", 32'(e), 32'd0);
        @(negedge clk);
        chk("mbox_done", 32'(done_v[0]), 32'd1);
        chk("mbox_done_value", done_value_v[0], 32'h0000_0400);
        txn(0, 1'b0, 32'hFC4, 32'h0, 1'b0, rd, e, lat);
        chk("mbox_rd", rd, 32'h0000_0400);
        chk("mbox_rd_err", 32'(e), 32'd0);
`else
        chk("mbox_wr_err", 32'(e), 32'd1);
        @(negedge clk);
        chk("mbox_done", 32'(done_v[0]), 32'd0);
        chk("mbox_done_value", done_value_v[0], 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
